// File: rtl/alu_writeback_if.sv
// rtl/alu_writeback_if.sv - ALU result / register-file write channel bundle
//
// Purpose: groups the two handshake channels of alu_writeback.
//   ALU result channel : in_valid, in_ready, rslt, sc_o, zero, pari,
//                        dest, wr_req, set_c
//   Register-file port : rf_we, rf_waddr, rf_wdata, rf_ready
// Modports:
//   master - the surroundings (ALU and register file) that drive the block
//   slave  - the alu_writeback block itself
interface alu_writeback_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] rslt;
    logic          sc_o;
    logic          zero;
    logic          pari;
    logic [AW-1:0] dest;
    logic          wr_req;
    logic          set_c;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rf_ready;

    modport master (
        output in_valid, rslt, sc_o, zero, pari, dest, wr_req, set_c, rf_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  in_valid, rslt, sc_o, zero, pari, dest, wr_req, set_c, rf_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU writeback stage: 2-entry register-write FIFO plus flag registers
//
// Purpose: accepts ALU results, queues register writes in a 2-entry FIFO
// toward the register file, and updates the architectural flags at accept
// time so the next ALU op sees the new carry on the following cycle.
// Ports:
//   clk, reset  - single clock, synchronous active-high reset
//   bus         - alu_writeback_if.slave (ALU result channel + RF write port)
//   carry_q, zero_q, pari_q - architectural flags (carry_q feeds ALU sc_i)
//   retire_cnt  - saturating count of register writes retired
// Optional feature (macro ALU_WB_BYPASS_EN):
//   byp_raddr in, byp_hit / byp_data out - combinational lookup of the
//   youngest pending write to a register.
module alu_writeback #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    alu_writeback_if.slave bus,
    output logic          carry_q,
    output logic          zero_q,
    output logic          pari_q,
    output logic [15:0]   retire_cnt
`ifdef ALU_WB_BYPASS_EN
    ,
    input  logic [AW-1:0] byp_raddr,
    output logic          byp_hit,
    output logic [DW-1:0] byp_data
`endif
);

    logic [AW-1:0] addr_mem [2];
    logic [DW-1:0] data_mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;

    logic accept;
    logic push;
    logic pop;

    // in_ready depends only on occupancy, never on rf_ready, so a full
    // buffer refuses input even in a cycle where it is being drained.
    assign bus.in_ready = (count != 2'd2);
    assign accept       = bus.in_valid & bus.in_ready;
    assign push         = accept & bus.wr_req;
    assign pop          = bus.rf_we & bus.rf_ready;

    // Head is presented only from stored entries; an empty FIFO reads zero.
    assign bus.rf_we    = (count != 2'd0);
    assign bus.rf_waddr = bus.rf_we ? addr_mem[rd_ptr] : '0;
    assign bus.rf_wdata = bus.rf_we ? data_mem[rd_ptr] : '0;

    // Entry storage carries no reset: contents are only visible through
    // the count-gated head outputs above.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            addr_mem[wr_ptr] <= bus.dest;
            data_mem[wr_ptr] <= bus.rslt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            pari_q     <= 1'b0;
            retire_cnt <= 16'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            // Flags follow every accepted op, including ones that do not
            // write a register.
            if (accept) begin
                zero_q <= bus.zero;
                pari_q <= bus.pari;
                if (bus.set_c) begin
                    carry_q <= bus.sc_o;
                end
            end

            if (pop && (retire_cnt != 16'hFFFF)) begin
                retire_cnt <= retire_cnt + 16'd1;
            end
        end
    end

`ifdef ALU_WB_BYPASS_EN
    // Youngest entry sits just behind wr_ptr; the other slot is only live
    // when both entries are occupied.
    logic young_idx;
    logic young_hit;
    logic old_hit;

    assign young_idx = ~wr_ptr;
    assign young_hit = (count != 2'd0) && (addr_mem[young_idx] == byp_raddr);
    assign old_hit   = (count == 2'd2) && (addr_mem[wr_ptr] == byp_raddr);

    always_comb begin
        byp_hit  = young_hit | old_hit;
        byp_data = '0;
        if (young_hit) begin
            byp_data = data_mem[young_idx];
        end else if (old_hit) begin
            byp_data = data_mem[wr_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - directed self-checking bench for alu_writeback
module tb_alu_writeback;
    localparam int DW = 8;
    localparam int AW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        carry_q;
    logic        zero_q;
    logic        pari_q;
    logic [15:0] retire_cnt;
`ifdef ALU_WB_BYPASS_EN
    logic [AW-1:0] byp_raddr;
    logic          byp_hit;
    logic [DW-1:0] byp_data;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    alu_writeback_if #(.DW(DW), .AW(AW)) bus ();

    alu_writeback #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .carry_q    (carry_q),
        .zero_q     (zero_q),
        .pari_q     (pari_q),
        .retire_cnt (retire_cnt)
`ifdef ALU_WB_BYPASS_EN
        ,
        .byp_raddr  (byp_raddr),
        .byp_hit    (byp_hit),
        .byp_data   (byp_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] d, input logic [DW-1:0] r,
                         input logic w, input logic sc, input logic s, input logic z,
                         input logic p);
        bus.in_valid = v;
        bus.dest     = d;
        bus.rslt     = r;
        bus.wr_req   = w;
        bus.sc_o     = sc;
        bus.set_c    = s;
        bus.zero     = z;
        bus.pari     = p;
    endtask

    initial begin
        reset        = 1'b1;
        bus.rf_ready = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_WB_BYPASS_EN
        byp_raddr = 3'd0;
`endif

        // Reset state
        tick();
        tick();
        #1;
        chk("rst_rf_we", bus.rf_we, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_flags", {carry_q, zero_q, pari_q}, 0);
        chk("rst_retire", retire_cnt, 0);
        chk("rst_waddr", bus.rf_waddr, 0);
        chk("rst_wdata", bus.rf_wdata, 0);
        reset = 1'b0;

        // Single write, RF ready
        bus.rf_ready = 1'b1;
        drive(1'b1, 3'd3, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("single_no_forward", bus.rf_we, 0);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("single_rf_we", bus.rf_we, 1);
        chk("single_waddr", bus.rf_waddr, 3);
        chk("single_wdata", bus.rf_wdata, 8'h5A);
        tick();
        #1;
        chk("single_drained", bus.rf_we, 0);
        chk("single_retire", retire_cnt, 1);

        // Back-to-back writes with RF stalled
        bus.rf_ready = 1'b0;
        drive(1'b1, 3'd1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd2, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("b2b_ready_1", bus.in_ready, 1);
        chk("b2b_head_1", {bus.rf_waddr, bus.rf_wdata}, {3'd1, 8'h11});
        tick();
        drive(1'b1, 3'd4, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("b2b_full", bus.in_ready, 0);
        chk("b2b_head_2", {bus.rf_waddr, bus.rf_wdata}, {3'd1, 8'h11});
        tick();
        #1;
        chk("b2b_held", bus.in_ready, 0);
        chk("b2b_head_stable", {bus.rf_waddr, bus.rf_wdata}, {3'd1, 8'h11});
        bus.rf_ready = 1'b1;
        tick();
        #1;
        chk("b2b_pop1_head", {bus.rf_waddr, bus.rf_wdata}, {3'd2, 8'h22});
        chk("b2b_pop1_ready", bus.in_ready, 1);
        chk("b2b_pop1_cnt", retire_cnt, 2);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("b2b_pushpop_head", {bus.rf_we, bus.rf_waddr, bus.rf_wdata}, {1'b1, 3'd4, 8'h33});
        chk("b2b_pushpop_cnt", retire_cnt, 3);
        tick();
        #1;
        chk("b2b_empty", bus.rf_we, 0);
        chk("b2b_final_cnt", retire_cnt, 4);

        // Carry update only with set_c; zero/pari on every accept
        drive(1'b1, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        #1;
        chk("flags_op1", {carry_q, zero_q, pari_q}, 3'b110);
        drive(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        #1;
        chk("flags_op2", {carry_q, zero_q, pari_q}, 3'b101);
        drive(1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        #1;
        chk("flags_carry_clr", {carry_q, zero_q, pari_q}, 3'b000);

        // Accept without register write
        drive(1'b1, 3'd6, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("nowr_zero", zero_q, 1);
        chk("nowr_rf_we", bus.rf_we, 0);
        chk("nowr_retire", retire_cnt, 4);
        tick();
        #1;
        chk("idle_flags_hold", zero_q, 1);

        // Reset with two entries pending
        bus.rf_ready = 1'b0;
        drive(1'b1, 3'd6, 8'h66, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 3'd7, 8'h77, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        #1;
        chk("pend_full", bus.in_ready, 0);
        chk("pend_flags", {carry_q, zero_q, pari_q}, 3'b111);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("midrst_rf_we", bus.rf_we, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_flags", {carry_q, zero_q, pari_q}, 0);
        chk("midrst_retire", retire_cnt, 0);
        chk("midrst_waddr", bus.rf_waddr, 0);
        tick();
        #1;
        chk("midrst_no_push", bus.rf_we, 0);

`ifdef ALU_WB_BYPASS_EN
        // Youngest-match bypass lookup
        drive(1'b1, 3'd5, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 3'd5, 8'hBB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        byp_raddr = 3'd5;
        #1;
        chk("byp_hit5", byp_hit, 1);
        chk("byp_data5", byp_data, 8'hBB);
        byp_raddr = 3'd2;
        #1;
        chk("byp_miss2", byp_hit, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DW, default 8: datapath width, matching the ALU result width.
REQ-002 Parameter AW, default 3: register-file address width.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port in_valid  input  1: ALU result presented this cycle.
REQ-006 Port in_ready  output  1: block accepts the ALU result this cycle.
REQ-007 Port rslt  input  DW: ALU result.
REQ-008 Port sc_o, zero, pari  input  1 each: ALU carry-out, zero and parity flags.
REQ-009 Port dest  input  AW: destination register address.
REQ-010 Port wr_req  input  1: instruction writes rslt to dest.
REQ-011 Port set_c  input  1: instruction updates the carry flag.
REQ-012 Port rf_we  output  1: write request to the register file (head entry valid).
REQ-013 Port rf_waddr  output  AW, rf_wdata  output  DW: head entry address and data.
REQ-014 Port rf_ready  input  1: register file consumes the head entry this cycle.
REQ-015 Port carry_q, zero_q, pari_q  output  1 each: architectural flags; carry_q drives ALU sc_i.
REQ-016 Port retire_cnt  output  16: count of register writes retired.

Function
REQ-017 Accept occurs when in_valid=1 and in_ready=1; in_ready SHALL be 1 iff the buffer holds fewer than 2 entries, with no combinational dependence on rf_ready.
REQ-018 On accept with wr_req=1, {dest, rslt} SHALL be pushed into a 2-entry FIFO; with wr_req=0 nothing is pushed, but the accept still updates the flags.
REQ-019 rf_we SHALL equal 1 iff the FIFO is non-empty; rf_waddr/rf_wdata SHALL show the oldest entry; accept-to-rf_we latency is exactly 1 cycle.
REQ-020 Pop occurs when rf_we=1 and rf_ready=1; the head entry SHALL remain stable while rf_ready=0.
REQ-021 Simultaneous push and pop SHALL leave the count unchanged and preserve order; push when empty SHALL NOT forward data in the same cycle.
REQ-022 On every accept, zero_q<=zero and pari_q<=pari; carry_q<=sc_o only when set_c=1, otherwise carry_q is held.
REQ-023 Flags SHALL update at accept time, not at retire, so the next ALU op sees the new carry_q on the following cycle.
REQ-024 retire_cnt SHALL increment by 1 per pop and saturate at 16'hFFFF.
REQ-025 FIFO pointers SHALL wrap modulo 2; the count SHALL never exceed 2 or fall below 0.

Reset
REQ-026 When reset=1 at a clock edge: the FIFO is emptied, rf_we=0, in_ready=1, carry_q=0, zero_q=0, pari_q=0, retire_cnt=0.
REQ-027 Reset mid-operation SHALL discard pending entries without issuing rf_we; inputs during the reset cycle are ignored.
REQ-028 rf_waddr/rf_wdata SHALL read 0 while the FIFO is empty after reset.

Configuration
REQ-029 Macro ALU_WB_BYPASS_EN, when defined, SHALL add input byp_raddr[AW-1:0] and outputs byp_hit and byp_data[DW-1:0].
REQ-030 With the macro defined, byp_hit=1 iff a FIFO entry matches byp_raddr, and byp_data SHALL give the youngest matching entry's data, combinationally.
REQ-031 Without ALU_WB_BYPASS_EN, these ports and the compare logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 Reset, then one accept {dest=3, rslt=8'h5A, wr_req=1} with rf_ready=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=5A; following cycle rf_we=0; retire_cnt=1.
REQ-033 rf_ready=0 and three back-to-back valid writes (11, 22, 33) -> in_ready=0 after two accepts; the third is held; releasing rf_ready retires 11, 22, 33 in order.
REQ-034 Accept sc_o=1 with set_c=1, then sc_o=0 with set_c=0 -> carry_q=1 after both; zero_q/pari_q track the second op.
REQ-035 Accept with wr_req=0 and zero=1 -> zero_q=1, rf_we stays 0, retire_cnt unchanged.
REQ-036 Reset asserted with 2 entries pending and rf_ready=0 -> next cycle rf_we=0, in_ready=1, flags=0, retire_cnt=0.
REQ-037 With ALU_WB_BYPASS_EN: entries dest=5/AA, then dest=5/BB pending, byp_raddr=5 -> byp_hit=1, byp_data=BB; byp_raddr=2 -> byp_hit=0.
